// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and frame data width.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receive engine: RXD synchronizer, bit-timing FSM and shift register.
// Emits a single-cycle byte_strobe or frame_err_strobe at the stop-sample edge.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BAUD_PERIOD_BITS = 16
) (
  input  logic                        clk,
  input  logic                        sync_reset,
  input  logic                        rxd,
  input  logic [BAUD_PERIOD_BITS-1:0] baud_rate_period_m1,
  output logic                        byte_strobe,
  output logic [UART_DATA_BITS-1:0]   byte_data,
  output logic                        frame_err_strobe,
  output logic                        rx_active
);

  logic                        rxd_meta;
  logic                        rxd_s;
  uart_rx_state_t              state, state_next;
  logic [BAUD_PERIOD_BITS-1:0] cnt, cnt_next;
  logic [BAUD_PERIOD_BITS-1:0] half_period;
  logic [2:0]                  bit_idx, bit_idx_next;
  logic [UART_DATA_BITS-1:0]   shreg, shreg_next;

  assign half_period = baud_rate_period_m1 >> 1;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      state    <= state_next;
      cnt      <= cnt_next;
      bit_idx  <= bit_idx_next;
      shreg    <= shreg_next;
    end
  end

  // Start bit is checked at mid-bit; every later sample lands one full period on.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt + 1'b1;
    bit_idx_next     = bit_idx;
    shreg_next       = shreg;
    byte_strobe      = 1'b0;
    frame_err_strobe = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rxd_s) state_next = START;
      end
      START: begin
        if (cnt == half_period) begin
          cnt_next = '0;
          if (rxd_s) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end
      end
      DATA: begin
        if (cnt == baud_rate_period_m1) begin
          cnt_next            = '0;
          shreg_next[bit_idx] = rxd_s;
          bit_idx_next        = bit_idx + 1'b1;
          if (bit_idx == 3'(UART_DATA_BITS - 1)) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == baud_rate_period_m1) begin
          cnt_next = '0;
          if (rxd_s) begin
            byte_strobe = 1'b1;
            state_next  = IDLE;
          end else begin
            frame_err_strobe = 1'b1;
            state_next       = BREAK;
          end
        end
      end
      BREAK: begin
        // A held-low line must not be decoded as a stream of 0x00 frames.
        cnt_next = '0;
        if (rxd_s) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign byte_data = shreg;
  assign rx_active = (state != IDLE);

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with a first-word-fall-through byte FIFO and sticky overrun/frame error flags.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int BAUD_PERIOD_BITS = 16,
  parameter int FIFO_DEPTH_LOG2  = 3
) (
  input  logic                        clk,
  input  logic                        sync_reset,
  input  logic                        RXD,
  input  logic [BAUD_PERIOD_BITS-1:0] baud_rate_period_m1,
  input  logic                        rd_pop,
  input  logic                        err_clear,
  output logic [UART_DATA_BITS-1:0]   rx_data,
  output logic                        rx_valid,
  output logic [FIFO_DEPTH_LOG2:0]    rx_count,
  output logic                        overrun,
  output logic                        frame_error,
  output logic                        rx_active
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic                        byte_strobe;
  logic [UART_DATA_BITS-1:0]   byte_data;
  logic                        frame_err_strobe;

  logic [UART_DATA_BITS-1:0]   mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]    count;
  logic                        full;
  logic                        empty;
  logic                        do_push;
  logic                        do_pop;
  logic                        drop;

  uart_rx_core #(
    .BAUD_PERIOD_BITS(BAUD_PERIOD_BITS)
  ) u_core (
    .clk                 (clk),
    .sync_reset          (sync_reset),
    .rxd                 (RXD),
    .baud_rate_period_m1 (baud_rate_period_m1),
    .byte_strobe         (byte_strobe),
    .byte_data           (byte_data),
    .frame_err_strobe    (frame_err_strobe),
    .rx_active           (rx_active)
  );

  assign full  = (count == (FIFO_DEPTH_LOG2 + 1)'(DEPTH));
  assign empty = (count == '0);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = rd_pop && !empty;
  assign do_push = byte_strobe && (!full || do_pop);
  assign drop    = byte_strobe && full && !do_pop;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= byte_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;

      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (drop)           overrun <= 1'b1;
      else if (err_clear) overrun <= 1'b0;

      if (frame_err_strobe) frame_error <= 1'b1;
      else if (err_clear)   frame_error <= 1'b0;
    end
  end

  assign rx_data  = mem[rd_ptr];
  assign rx_valid = !empty;
  assign rx_count = count;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered at P=16: frame table plus glitch, break,
// overrun, pop-on-full-push and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_buffered;

  localparam int BIT_CYC = 16;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic        RXD;
  logic [15:0] baud_rate_period_m1;
  logic        rd_pop;
  logic        err_clear;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [3:0]  rx_count;
  logic        overrun;
  logic        frame_error;
  logic        rx_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  logic valid_q = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_head;
    int         exp_count;
    int         exp_latency;
    logic       pop;
    logic       exp_valid_after;
    logic [7:0] exp_head_after;
  } vec_t;

  vec_t vecs[5];

  uart_rx_buffered dut (
    .clk                 (clk),
    .sync_reset          (sync_reset),
    .RXD                 (RXD),
    .baud_rate_period_m1 (baud_rate_period_m1),
    .rd_pop              (rd_pop),
    .err_clear           (err_clear),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .rx_count            (rx_count),
    .overrun             (overrun),
    .frame_error         (frame_error),
    .rx_active           (rx_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records the cycle of each rising edge of rx_valid for latency checks.
  always @(posedge clk) begin
    #2;
    if (rx_valid && !valid_q) rise_cyc = cyc;
    valid_q = rx_valid;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one 8N1 frame; optionally pops at offset pop_at or resets at offset abort_at.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit,
                                input int pop_at, input int abort_at);
    logic [9:0] frame;
    frame     = {stop_bit, data, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10 * BIT_CYC; i++) begin
      if (i == abort_at) begin
        check_output("active_before_reset", rx_active, 1);
        sync_reset = 1'b1;
        RXD        = 1'b1;
        rd_pop     = 1'b0;
        step();
        sync_reset = 1'b0;
        return;
      end
      RXD    = frame[i / BIT_CYC];
      rd_pop = (i == pop_at);
      step();
    end
    rd_pop = 1'b0;
    RXD    = 1'b1;
  endtask

  task automatic pop_once();
    rd_pop = 1'b1;
    step();
    rd_pop = 1'b0;
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 1, 155, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{8'hFF, 8'hFF, 1, 155, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{8'h00, 8'h00, 1, 155, 1'b0, 1'b1, 8'h00};
    vecs[3] = '{8'h81, 8'h00, 2,  -1, 1'b1, 1'b1, 8'h81};
    vecs[4] = '{8'h6E, 8'h81, 2,  -1, 1'b1, 1'b1, 8'h6E};

    sync_reset          = 1'b1;
    RXD                 = 1'b1;
    rd_pop              = 1'b0;
    err_clear           = 1'b0;
    baud_rate_period_m1 = 16'd15;
    step(3);
    sync_reset = 1'b0;
    check_output("reset_valid", rx_valid, 0);
    check_output("reset_count", rx_count, 0);
    check_output("reset_overrun", overrun, 0);
    check_output("reset_frame_error", frame_error, 0);
    check_output("reset_active", rx_active, 0);
    check_output("reset_data", rx_data, 0);
    step(4);

    for (int v = 0; v < 5; v++) begin
      apply_stimulus(vecs[v].data, 1'b1, -1, -1);
      if (vecs[v].exp_latency >= 0)
        check_output($sformatf("vec%0d_latency", v), rise_cyc - start_cyc, vecs[v].exp_latency);
      else
        check_output($sformatf("vec%0d_no_new_rise", v), rise_cyc < start_cyc, 1);
      check_output($sformatf("vec%0d_head", v), rx_data, vecs[v].exp_head);
      check_output($sformatf("vec%0d_count", v), rx_count, vecs[v].exp_count);
      check_output($sformatf("vec%0d_frame_error", v), frame_error, 0);
      if (vecs[v].pop) begin
        pop_once();
        check_output($sformatf("vec%0d_valid_after_pop", v), rx_valid, vecs[v].exp_valid_after);
        if (vecs[v].exp_valid_after)
          check_output($sformatf("vec%0d_head_after_pop", v), rx_data, vecs[v].exp_head_after);
      end
    end
    pop_once();
    check_output("table_drained", rx_valid, 0);
    step(4);

    // Glitch: 4 low cycles, rejected at the mid-start sample.
    RXD = 1'b0;
    step(3);
    check_output("glitch_active_rise", rx_active, 1);
    step(1);
    RXD = 1'b1;
    step(6);
    check_output("glitch_active_hold", rx_active, 1);
    step(1);
    check_output("glitch_active_fall", rx_active, 0);
    check_output("glitch_count", rx_count, 0);
    check_output("glitch_frame_error", frame_error, 0);
    step(2 * BIT_CYC);

    // Bad stop bit followed by a 40-bit break.
    apply_stimulus(8'h3C, 1'b0, -1, -1);
    RXD = 1'b0;
    step(40 * BIT_CYC);
    check_output("break_frame_error", frame_error, 1);
    check_output("break_count", rx_count, 0);
    check_output("break_active", rx_active, 1);
    RXD = 1'b1;
    step(4);
    check_output("break_exit_idle", rx_active, 0);
    step(BIT_CYC);
    apply_stimulus(8'h55, 1'b1, -1, -1);
    check_output("after_break_data", rx_data, 8'h55);
    check_output("after_break_count", rx_count, 1);
    check_output("frame_error_sticky", frame_error, 1);
    pulse_err_clear();
    check_output("frame_error_cleared", frame_error, 0);
    pop_once();
    check_output("after_break_drained", rx_valid, 0);

    // Nine bytes into an eight-entry FIFO.
    for (int b = 0; b < 9; b++) apply_stimulus(8'(b), 1'b1, -1, -1);
    check_output("overrun_count", rx_count, 8);
    check_output("overrun_flag", overrun, 1);
    for (int b = 0; b < 8; b++) begin
      check_output($sformatf("overrun_pop%0d", b), rx_data, b);
      pop_once();
    end
    check_output("overrun_drained", rx_valid, 0);
    check_output("overrun_sticky", overrun, 1);
    pulse_err_clear();
    check_output("overrun_cleared", overrun, 0);

    // Pop lands on the same edge as the ninth push.
    for (int b = 0; b < 8; b++) apply_stimulus(8'h10 + 8'(b), 1'b1, -1, -1);
    check_output("full_count", rx_count, 8);
    apply_stimulus(8'h99, 1'b1, 154, -1);
    check_output("pop_push_count", rx_count, 8);
    check_output("pop_push_overrun", overrun, 0);
    for (int b = 0; b < 8; b++) begin
      check_output($sformatf("pop_push_drain%0d", b), rx_data, (b == 7) ? 8'h99 : 8'h11 + 8'(b));
      pop_once();
    end
    check_output("pop_push_drained", rx_valid, 0);

    // Reset during DATA bit 3 with one byte queued.
    apply_stimulus(8'h42, 1'b1, -1, -1);
    check_output("pre_reset_data", rx_data, 8'h42);
    apply_stimulus(8'hF0, 1'b1, -1, 68);
    check_output("midreset_valid", rx_valid, 0);
    check_output("midreset_count", rx_count, 0);
    check_output("midreset_overrun", overrun, 0);
    check_output("midreset_frame_error", frame_error, 0);
    check_output("midreset_active", rx_active, 0);
    check_output("midreset_data", rx_data, 0);
    step(3 * BIT_CYC);
    check_output("midreset_stays_idle", rx_active, 0);
    apply_stimulus(8'hC3, 1'b1, -1, -1);
    check_output("post_reset_latency", rise_cyc - start_cyc, 155);
    check_output("post_reset_data", rx_data, 8'hC3);
    check_output("post_reset_count", rx_count, 1);
    check_output("post_reset_frame_error", frame_error, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
